// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and the default address type.
package y86_pkg;

  localparam int Y86_ADDR_W = 64;

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  typedef logic [Y86_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/pc_ras_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// an empty pop leaves the state alone. Both cases raise sticky flags.
module pc_ras_stack
  import y86_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [ADDR_W-1:0]        push_data_i,
  output logic [ADDR_W-1:0]        top_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_o,
  output logic                     unf_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, top_ptr;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  // ptr_q is the next free slot; the top sits one below it, modulo DEPTH.
  assign top_ptr = ptr_q - PTR_ONE;
  assign top_o   = mem_q[top_ptr];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_ONE;
      if (cnt_q == CNT_FULL) ovf_d = 1'b1;
      else                   cnt_d = cnt_q + CNT_ONE;
    end else if (pop_i) begin
      if (cnt_q == '0) begin
        unf_d = 1'b1;
      end else begin
        ptr_d = ptr_q - PTR_ONE;
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is deliberately not reset; entries are only read after a push.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-PC register and next-PC predictor (jXX taken, call/ret via RAS).
// Optional return-address stack enabled by defining PC_PREDICT_RAS_EN.
module pc_predict_unit
  import y86_pkg::*;
#(
  parameter int                RAS_DEPTH = 8,
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall_f,
  input  logic [3:0]                   f_icode,
  input  logic [ADDR_W-1:0]            f_valC,
  input  logic [ADDR_W-1:0]            f_valP,
  input  logic                         m_mispredict,
  input  logic [ADDR_W-1:0]            m_valA,
  input  logic                         w_ret,
  input  logic [ADDR_W-1:0]            w_valM,
  output logic [ADDR_W-1:0]            pc_f,
  output logic [ADDR_W-1:0]            pred_pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf
);

  logic [ADDR_W-1:0] pred_q, pred_d;
  logic [ADDR_W-1:0] ret_pred;

  always_comb begin
    if (m_mispredict) pc_f = m_valA;
    else if (w_ret)   pc_f = w_valM;
    else              pc_f = pred_q;
  end

`ifdef PC_PREDICT_RAS_EN
  logic              ras_push, ras_pop, ras_empty;
  logic [ADDR_W-1:0] ras_top;

  // The fetched instruction is always correct-path, so it updates the RAS
  // even while a late correction is steering pc_f.
  assign ras_push = !stall_f && (f_icode == ICALL);
  assign ras_pop  = !stall_f && (f_icode == IRET);

  pc_ras_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (f_valP),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .count_o     (ras_count),
    .ovf_o       (ras_ovf),
    .unf_o       (ras_unf)
  );

  assign ret_pred = ras_empty ? f_valP : ras_top;
`else
  // Without a RAS, ret falls through and the writeback correction fixes it.
  assign ret_pred  = f_valP;
  assign ras_count = '0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;
`endif

  always_comb begin
    case (f_icode)
      IJXX, ICALL: pred_d = f_valC;
      IRET:        pred_d = ret_pred;
      IHALT:       pred_d = f_valP;
      default:     pred_d = f_valP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pred_q <= RESET_PC;
    else if (!stall_f) pred_q <= pred_d;
  end

  assign pred_pc = pred_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Scoreboard bench for pc_predict_unit; follows PC_PREDICT_RAS_EN if defined.
module tb_pc_predict_unit;

  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

`ifdef PC_PREDICT_RAS_EN
  localparam bit R = 1'b1;
`else
  localparam bit R = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall_f = 1'b0;
  logic [3:0]    f_icode = 4'h1;
  logic [63:0]   f_valC = '0, f_valP = '0, m_valA = '0, w_valM = '0;
  logic          m_mispredict = 1'b0, w_ret = 1'b0;
  logic [63:0]   pc_f, pred_pc;
  logic [CW-1:0] ras_count;
  logic          ras_ovf, ras_unf;

  pc_predict_unit #(
    .RAS_DEPTH (D),
    .ADDR_W    (64),
    .RESET_PC  (64'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_f      (stall_f),
    .f_icode      (f_icode),
    .f_valC       (f_valC),
    .f_valP       (f_valP),
    .m_mispredict (m_mispredict),
    .m_valA       (m_valA),
    .w_ret        (w_ret),
    .w_valM       (w_valM),
    .pc_f         (pc_f),
    .pred_pc      (pred_pc),
    .ras_count    (ras_count),
    .ras_ovf      (ras_ovf),
    .ras_unf      (ras_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] pcf;
    logic [63:0] pred;
    int          cnt;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  function automatic int rc(input int n);
    return R ? n : 0;
  endfunction

  function automatic logic [63:0] rsel(input logic [63:0] with_ras, input logic [63:0] without_ras);
    return R ? with_ras : without_ras;
  endfunction

  task automatic vec(input string nm, input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp,
                     input bit st, input bit mis, input logic [63:0] ma, input bit wr, input logic [63:0] wm,
                     input logic [63:0] e_pcf, input logic [63:0] e_pred, input int e_cnt,
                     input bit e_ovf, input bit e_unf);
    @(posedge clk);
    #1;
    f_icode = ic; f_valC = vc; f_valP = vp; stall_f = st;
    m_mispredict = mis; m_valA = ma; w_ret = wr; w_valM = wm;
    q.push_back('{name: nm, pcf: e_pcf, pred: e_pred, cnt: e_cnt, ovf: e_ovf, unf: e_unf});
  endtask

  // Monitor: one expectation per cycle, compared away from the rising edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (pc_f !== e.pcf || pred_pc !== e.pred || int'(ras_count) != e.cnt ||
          ras_ovf !== e.ovf || ras_unf !== e.unf) begin
        errors++;
        $display("FAIL %s: got pc_f=%h pred_pc=%h cnt=%0d ovf=%b unf=%b, want pc_f=%h pred_pc=%h cnt=%0d ovf=%b unf=%b",
                 e.name, pc_f, pred_pc, ras_count, ras_ovf, ras_unf, e.pcf, e.pred, e.cnt, e.ovf, e.unf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  logic [63:0] prev;

  initial begin
    // Held in reset, then released with a harmless nop whose valP is RESET_PC.
    vec("reset", 4'h1, 64'h0, 64'h0, 0, 0, 64'h0, 0, 64'h0, 64'h0, 64'h0, 0, 0, 0);
    @(negedge clk); #1 rst = 1'b0;

    vec("irmovq",     4'h3, 64'h0,   64'h0A, 0, 0, 64'h0,  0, 64'h0,  64'h00, 64'h00, 0, 0, 0);
    vec("jxx_fetch",  4'h7, 64'h40,  64'h09, 0, 0, 64'h0,  0, 64'h0,  64'h0A, 64'h0A, 0, 0, 0);
    vec("jxx_taken",  4'h6, 64'h0,   64'h42, 0, 0, 64'h0,  0, 64'h0,  64'h40, 64'h40, 0, 0, 0);
    vec("jxx_next",   4'h3, 64'h0,   64'h4C, 0, 0, 64'h0,  0, 64'h0,  64'h42, 64'h42, 0, 0, 0);
    vec("mispredict", 4'h3, 64'h0,   64'h13, 0, 1, 64'h09, 0, 64'h0,  64'h09, 64'h4C, 0, 0, 0);
    vec("call",       4'h8, 64'h100, 64'h20, 0, 0, 64'h0,  0, 64'h0,  64'h13, 64'h13, 0, 0, 0);
    vec("ret",        4'h9, 64'h0,   64'h101, 0, 0, 64'h0, 0, 64'h0,  64'h100, 64'h100, rc(1), 0, 0);
    vec("ret_wfix",   4'h1, 64'h0,   64'h21, 0, 0, 64'h0,  1, 64'h20, 64'h20, rsel(64'h20, 64'h101), 0, 0, 0);
    vec("both_corr",  4'h1, 64'h0,   64'h56, 0, 1, 64'h55, 1, 64'h66, 64'h55, 64'h21, 0, 0, 0);

    for (int s = 0; s < 3; s++)
      vec("stall_call", 4'h8, 64'h200, 64'h60, 1, 0, 64'h0, 0, 64'h0, 64'h56, 64'h56, 0, 0, 0);
    vec("unstall_call", 4'h8, 64'h200, 64'h60, 0, 0, 64'h0, 0, 64'h0, 64'h56, 64'h56, 0, 0, 0);
    vec("stall_ret",  4'h9, 64'h0,   64'h201, 0, 0, 64'h0, 0, 64'h0, 64'h200, 64'h200, rc(1), 0, 0);

    // D+1 nested calls: the last one overwrites the oldest entry.
    prev = rsel(64'h60, 64'h201);
    for (int k = 0; k <= D; k++) begin
      vec("nest_call", 4'h8, 64'h300 + 64'(k * 16), 64'h1000 + 64'(k), 0, 0, 64'h0, 0, 64'h0,
          prev, prev, rc(k), 0, 0);
      prev = 64'h300 + 64'(k * 16);
    end
    // D+1 rets: newest-first down to the second oldest, then one underflow.
    for (int j = 0; j <= D; j++) begin
      vec("nest_ret", 4'h9, 64'h0, 64'h2000 + 64'(j), 0, 0, 64'h0, 0, 64'h0,
          prev, prev, rc(D - j), R, 0);
      prev = (R && j < D) ? 64'h1000 + 64'(D - j) : 64'h2000 + 64'(j);
    end
    vec("after_unf", 4'h1, 64'h0, 64'h3000, 0, 0, 64'h0, 0, 64'h0, prev, prev, 0, R, R);

    // Asynchronous reset pulse in the middle of a cycle.
    @(posedge clk);
    #1;
    f_icode = 4'h1; f_valC = '0; f_valP = 64'h77; stall_f = 1'b0;
    m_mispredict = 1'b0; w_ret = 1'b0;
    rst = 1'b1;
    #1;
    q.push_back('{name: "async_rst", pcf: 64'h0, pred: 64'h0, cnt: 0, ovf: 1'b0, unf: 1'b0});
    @(negedge clk); #1 rst = 1'b0;
    vec("post_rst", 4'h1, 64'h0, 64'h80, 0, 0, 64'h0, 0, 64'h0, 64'h77, 64'h77, 0, 0, 0);

    @(negedge clk);
    #1;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
